lsu_rmw: RTL

- Load/store unit between the single-cycle core's execute stage and data_memory.
- Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned full-word memory accesses. data_memory has no byte enables and a registered read.
- Extracts and sign-/zero-extends load data.
- Performs sub-word stores by read-modify-write.
- Flags misaligned, out-of-range and illegal accesses without touching memory.

---
 rtl/lsu_rmw.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rmw
// Purpose  : Load/store unit between an RV32I execute stage and a word-wide
//            data memory that has a registered read and no byte enables.
//            Loads are widened to full-word reads, then the selected byte or
//            half is extracted and sign/zero-extended. Sub-word stores are
//            done as read-modify-write. Misaligned, out-of-range and illegal
//            funct3 requests finish with err=1 and never touch memory.
// Ports    : clk, rst (sync, active-high)
//            req/we/funct3/addr/wdata   - request, sampled only when idle
//            busy/done/err/rdata        - status and load result
//            mem_address/mem_read/mem_write/mem_wdata/mem_rdata
//                                       - data_memory interface
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned BASE = 'h1000,
  parameter int unsigned SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Lowest and highest legal word addresses.
  localparam logic [AW-1:0] C_LO = AW'(BASE);
  localparam logic [AW-1:0] C_HI = AW'(BASE + SIZE - 4);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [15:0]   wsub_q;   // only the low half of store data is ever merged
  logic          err_q;
  logic [AW-1:0] mem_address_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  // --------------------------------------------------------------------------
  // Accept-time decode of the incoming request
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_waddr;
  logic          w_f3_ok;
  logic          w_misal;
  logic          w_oor;
  logic          w_err;

  assign w_waddr = {addr[AW-1:2], 2'b00};

  always_comb begin
    w_f3_ok = 1'b0;
    if (we) begin
      w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

  assign w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_oor   = (w_waddr < C_LO) || (w_waddr > C_HI);
  assign w_err   = !w_f3_ok || w_misal || w_oor;

  // --------------------------------------------------------------------------
  // Load extraction and store merge, both working on the captured word
  // --------------------------------------------------------------------------
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_merge;

  assign w_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign w_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    case (f3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    if (f3_q[1:0] == 2'b00) begin
      w_merge[{off_q, 3'b000} +: 8] = wsub_q[7:0];
    end else begin
      w_merge[{off_q[1], 4'b0000} +: 16] = wsub_q;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (w_err) begin
            state_d = RESP;
          end else if (we && (funct3 == 3'b010)) begin
            state_d = WR;            // full-word store needs no read
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_read = 1'b1;
        state_d  = CAP;
      end
      CAP: begin
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      wsub_q        <= 16'd0;
      err_q         <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            f3_q   <= funct3;
            off_q  <= addr[1:0];
            wsub_q <= wdata[15:0];
            err_q  <= w_err;
            if (!w_err) begin
              mem_address_q <= w_waddr;
              mem_wdata_q   <= wdata;   // final value for SW, replaced for SB/SH
            end
            // A failed load still completes, with a zero result.
            if (w_err && !we) begin
              rdata_q <= '0;
            end
          end
        end
        CAP: begin
          if (we_q) begin
            mem_wdata_q <= w_merge;
          end else begin
            rdata_q <= w_load;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;

endmodule
`default_nettype wire
